// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: MEM-stage, CP0 and fetch-redirect signals of the exception sequencer
interface exc_sequencer_if;
   logic [5:0]  int_i;
   logic        timer_int_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_delayslot_i;
   logic [4:0]  mem_exc_i;
   logic        stall_i;
   logic [5:0]  int_o;
   logic [31:0] excepttype_o;
   logic [31:0] cp0_pc_o;
   logic        cp0_delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        new_pc_valid_o;
   logic        busy_o;
   modport master (
      output int_i, timer_int_i, status_i, cause_i, epc_i, mem_valid_i, mem_pc_i,
             mem_delayslot_i, mem_exc_i, stall_i,
      input  int_o, excepttype_o, cp0_pc_o, cp0_delayslot_o, flush_o, new_pc_o,
             new_pc_valid_o, busy_o
   );
   modport slave (
      input  int_i, timer_int_i, status_i, cause_i, epc_i, mem_valid_i, mem_pc_i,
             mem_delayslot_i, mem_exc_i, stall_i,
      output int_o, excepttype_o, cp0_pc_o, cp0_delayslot_o, flush_o, new_pc_o,
             new_pc_valid_o, busy_o
   );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer: prioritises interrupts and MEM exceptions, strobes CP0 for one cycle,
// flushes the pipeline and redirects fetch to the handler or EPC.
module exc_sequencer #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input logic            clk,
   input logic            rst,
   exc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;
   localparam int SW = SYNC_STAGES * 6;
   state_t        state_q, state_d;
   logic [SW-1:0] sync_q, sync_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   code_q, code_d, pc_q, pc_d, tgt_q, tgt_d, code;
   logic          ds_q, ds_d, int_req, accept;
   logic [5:0]    ip;
   logic          unused_bits;
   assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2], bus.cause_i[31:10], bus.cause_i[7:0]};
   // timer shares hardware line 5 but bypasses the synchroniser
   assign bus.int_o = {sync_q[SW-1] | bus.timer_int_i, sync_q[SW-2 -: 5]};
   assign ip = (bus.int_o & bus.status_i[15:10]) | {4'b0, bus.cause_i[9:8] & bus.status_i[9:8]};
   assign int_req = |ip & bus.status_i[0] & ~bus.status_i[1];
   assign accept = bus.mem_valid_i & ~bus.stall_i & (int_req | |bus.mem_exc_i);
   assign code = int_req          ? 32'h1 :
                 bus.mem_exc_i[0] ? 32'ha :
                 bus.mem_exc_i[1] ? 32'h8 :
                 bus.mem_exc_i[2] ? 32'hd :
                 bus.mem_exc_i[3] ? 32'hc : 32'he;
   always_comb begin
      sync_d  = {sync_q[SW-7:0], bus.int_i};
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      pc_d    = pc_q;
      ds_d    = ds_q;
      tgt_d   = tgt_q;
      if (state_q == IDLE && accept) begin
         state_d = COMMIT;
         code_d  = code;
         pc_d    = bus.mem_pc_i;
         ds_d    = bus.mem_delayslot_i;
         tgt_d   = (code == 32'he) ? bus.epc_i : EXC_VECTOR;
      end else if (state_q == COMMIT) begin
         state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
         cnt_d   = 4'(FLUSH_CYCLES - 1);
      end else if (state_q == FLUSH) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = (cnt_q == 4'd1) ? IDLE : FLUSH;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         pc_q    <= '0;
         ds_q    <= 1'b0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         ds_q    <= ds_d;
         tgt_q   <= tgt_d;
      end
   end
   assign bus.excepttype_o    = (state_q == COMMIT) ? code_q : 32'h0;
   assign bus.new_pc_valid_o  = (state_q == COMMIT);
   assign bus.flush_o         = (state_q != IDLE);
   assign bus.busy_o          = (state_q != IDLE);
   assign bus.new_pc_o        = tgt_q;
   assign bus.cp0_pc_o        = pc_q;
   assign bus.cp0_delayslot_o = ds_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: two sequencers (2 and 4 flush cycles) driven identically and checked
// every cycle against a behavioural model, plus directed literal expectations.
module tb_exc_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [5:0]  int_i;
   logic        timer, valid, ds, stall;
   logic [31:0] status, cause, epc, pc;
   logic [4:0]  exc;
   exc_sequencer_if if0 ();
   exc_sequencer_if if1 ();
   assign if0.int_i = int_i;  assign if1.int_i = int_i;
   assign if0.timer_int_i = timer;  assign if1.timer_int_i = timer;
   assign if0.status_i = status;  assign if1.status_i = status;
   assign if0.cause_i = cause;  assign if1.cause_i = cause;
   assign if0.epc_i = epc;  assign if1.epc_i = epc;
   assign if0.mem_valid_i = valid;  assign if1.mem_valid_i = valid;
   assign if0.mem_pc_i = pc;  assign if1.mem_pc_i = pc;
   assign if0.mem_delayslot_i = ds;  assign if1.mem_delayslot_i = ds;
   assign if0.mem_exc_i = exc;  assign if1.mem_exc_i = exc;
   assign if0.stall_i = stall;  assign if1.stall_i = stall;
   exc_sequencer d0 (.clk(clk), .rst(rst), .bus(if0));
   exc_sequencer #(.FLUSH_CYCLES(4)) d1 (.clk(clk), .rst(rst), .bus(if1));
   logic [31:0] et[2], npc[2], cpc[2];
   logic [5:0]  io[2];
   logic        cds[2], fl[2], nv[2], bz[2];
   assign et[0] = if0.excepttype_o;  assign et[1] = if1.excepttype_o;
   assign npc[0] = if0.new_pc_o;  assign npc[1] = if1.new_pc_o;
   assign cpc[0] = if0.cp0_pc_o;  assign cpc[1] = if1.cp0_pc_o;
   assign io[0] = if0.int_o;  assign io[1] = if1.int_o;
   assign cds[0] = if0.cp0_delayslot_o;  assign cds[1] = if1.cp0_delayslot_o;
   assign fl[0] = if0.flush_o;  assign fl[1] = if1.flush_o;
   assign nv[0] = if0.new_pc_valid_o;  assign nv[1] = if1.new_pc_valid_o;
   assign bz[0] = if0.busy_o;  assign bz[1] = if1.busy_o;
   int errors = 0, checks = 0;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // behavioural model: remaining busy cycles per sequencer and captured event
   localparam logic [31:0] CODES [5] = '{32'ha, 32'h8, 32'hd, 32'hc, 32'he};
   int          fc [2] = '{2, 4};
   int          rem [2];
   bit          com [2];
   logic [31:0] m_code [2], m_pc [2], m_tgt [2];
   logic        m_ds [2];
   logic [5:0]  hist [$];
   bit          started = 0;
   function automatic logic [5:0] m_int();
      logic [5:0] s = (hist.size() == 2) ? hist[1] : 6'h0;
      return {s[5] | timer, s[4:0]};
   endfunction
   function automatic logic [31:0] prio(logic req, logic [4:0] e);
      if (req) return 32'h1;
      for (int i = 0; i < 5; i++) if (e[i]) return CODES[i];
      return 32'h0;
   endfunction
   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         hist.delete();
         for (int k = 0; k < 2; k++) begin
            rem[k] = 0; com[k] = 0; m_code[k] = 0; m_pc[k] = 0; m_tgt[k] = 0; m_ds[k] = 0;
         end
      end else begin
         logic [5:0] ipv;
         logic req;
         logic [31:0] c;
         ipv = (m_int() & status[15:10]) | {4'b0, cause[9:8] & status[9:8]};
         req = (ipv != 0) && status[0] && !status[1];
         c = prio(req, exc);
         for (int k = 0; k < 2; k++) begin
            com[k] = 0;
            if (rem[k] > 0) rem[k]--;
            else if (valid && !stall && (req || exc != 0)) begin
               rem[k] = fc[k]; com[k] = 1; m_code[k] = c; m_pc[k] = pc; m_ds[k] = ds;
               m_tgt[k] = (c == 32'he) ? epc : 32'h20;
            end
         end
         hist.push_front(int_i);
         if (hist.size() > 2) void'(hist.pop_back());
      end
   end
   always @(negedge clk) if (started) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("int_o%0d", k), 32'(io[k]), 32'(m_int()));
         chk($sformatf("excepttype%0d", k), et[k], com[k] ? m_code[k] : 32'h0);
         chk($sformatf("new_pc_valid%0d", k), 32'(nv[k]), 32'(com[k]));
         chk($sformatf("flush%0d", k), 32'(fl[k]), 32'(rem[k] > 0));
         chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(rem[k] > 0));
         chk($sformatf("new_pc%0d", k), npc[k], m_tgt[k]);
         chk($sformatf("cp0_pc%0d", k), cpc[k], m_pc[k]);
         chk($sformatf("cp0_ds%0d", k), 32'(cds[k]), 32'(m_ds[k]));
      end
   end
   task automatic quiet();
      int_i = 0; timer = 0; status = 0; cause = 0; epc = 0;
      valid = 0; pc = 0; ds = 0; exc = 0; stall = 0;
   endtask
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      quiet();
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bz[0]), 32'h0);
      chk("rst_flush", 32'(fl[0]), 32'h0);
      chk("rst_new_pc", npc[0], 32'h0);
      chk("rst_int_o", 32'(io[0]), 32'h0);
      step(1);
      rst = 0;
      // synchronised hardware interrupt accepted
      int_i = 6'b000100; status = 32'h0000_1001; valid = 1;
      @(negedge clk); chk("int_sync_1", 32'(io[0][2]), 32'h0);
      @(negedge clk); chk("int_sync_1b", 32'(io[0][2]), 32'h0);
      @(negedge clk); chk("int_sync_2", 32'(io[0][2]), 32'h1);
      @(negedge clk);
      chk("int_code", et[0], 32'h1);
      chk("int_target", npc[0], 32'h20);
      chk("int_strobe", 32'(nv[0]), 32'h1);
      chk("int_flush_a", 32'(fl[0]), 32'h1);
      step(1);
      valid = 0; int_i = 0;
      @(negedge clk);
      chk("int_flush_b", 32'(fl[0]), 32'h1);
      chk("int_strobe_off", 32'(nv[0]), 32'h0);
      @(negedge clk);
      chk("int_flush_end", 32'(fl[0]), 32'h0);
      step(6);
      // EXL blocks interrupts
      int_i = 6'b000100; status = 32'h0000_1003; valid = 1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("exl_busy", 32'(bz[0]), 32'h0);
      end
      quiet();
      step(4);
      // invalid outranks syscall
      exc = 5'b00011; pc = 32'h100; ds = 1; valid = 1;
      step(1);
      quiet();
      chk("inv_code", et[0], 32'ha);
      chk("inv_pc", cpc[0], 32'h100);
      chk("inv_ds", 32'(cds[0]), 32'h1);
      step(6);
      // eret redirects to EPC
      exc = 5'b10000; epc = 32'h400; valid = 1;
      step(1);
      quiet();
      chk("eret_code", et[0], 32'he);
      chk("eret_target", npc[0], 32'h400);
      chk("eret_strobe", 32'(nv[0]), 32'h1);
      step(1);
      chk("eret_strobe_off", 32'(nv[0]), 32'h0);
      chk("eret_target_hold", npc[0], 32'h400);
      step(6);
      // stalled syscall waits
      exc = 5'b00010; valid = 1; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("stall_busy", 32'(bz[0]), 32'h0);
      end
      stall = 0;
      step(1);
      quiet();
      chk("sys_code", et[0], 32'h8);
      chk("sys_strobe", 32'(nv[0]), 32'h1);
      step(6);
      // reset in the second flush cycle of the 4-cycle sequencer
      exc = 5'b01000; pc = 32'h200; valid = 1;
      step(1);
      quiet();
      chk("ovf_code", et[1], 32'hc);
      step(2);
      chk("mid_flush_busy", 32'(bz[1]), 32'h1);
      rst = 1;
      step(1);
      rst = 0;
      chk("rst_mid_flush", 32'(fl[1]), 32'h0);
      chk("rst_mid_busy", 32'(bz[1]), 32'h0);
      chk("rst_mid_strobe", 32'(nv[1]), 32'h0);
      step(1);
      chk("rst_mid_strobe2", 32'(nv[1]), 32'h0);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step(1);
         if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
         timer = ($urandom_range(0, 15) == 0);
         status = $urandom;
         status[0] = ($urandom_range(0, 3) != 0);
         status[1] = ($urandom_range(0, 3) == 0);
         cause = $urandom;
         epc = $urandom;
         pc = $urandom;
         ds = 1'($urandom);
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         exc = 5'($urandom & $urandom & $urandom);
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 0;
      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
